// File: rtl/tapasco_axi.sv
// AXI4 channel and bundle types for TaPaSCo master ports (4-bit ID) and the
// widened slave-side port (5-bit ID carrying the originating master index).
package tapasco_axi;

  localparam int unsigned IdWidth   = 4;
  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 32;
  localparam int unsigned UserWidth = 1;

  typedef logic [IdWidth-1:0]     id_t;
  typedef logic [IdWidth:0]       id_slv_t;
  typedef logic [AddrWidth-1:0]   addr_t;
  typedef logic [DataWidth-1:0]   data_t;
  typedef logic [DataWidth/8-1:0] strb_t;
  typedef logic [UserWidth-1:0]   user_t;

  // id must stay the first (most significant) field: the mux prepends the master index to it
  typedef struct packed {
    id_t        id;
    addr_t      addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
    logic       lock;
    logic [3:0] cache;
    logic [2:0] prot;
    logic [3:0] qos;
    logic [3:0] region;
    logic [5:0] atop;
    user_t      user;
  } aw_chan_t;

  typedef struct packed {
    id_slv_t    id;
    addr_t      addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
    logic       lock;
    logic [3:0] cache;
    logic [2:0] prot;
    logic [3:0] qos;
    logic [3:0] region;
    logic [5:0] atop;
    user_t      user;
  } aw_chan_slv_t;

  typedef struct packed {
    id_t        id;
    addr_t      addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
    logic       lock;
    logic [3:0] cache;
    logic [2:0] prot;
    logic [3:0] qos;
    logic [3:0] region;
    user_t      user;
  } ar_chan_t;

  typedef struct packed {
    id_slv_t    id;
    addr_t      addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
    logic       lock;
    logic [3:0] cache;
    logic [2:0] prot;
    logic [3:0] qos;
    logic [3:0] region;
    user_t      user;
  } ar_chan_slv_t;

  typedef struct packed {
    data_t data;
    strb_t strb;
    logic  last;
    user_t user;
  } w_chan_t;

  typedef struct packed {
    id_t        id;
    logic [1:0] resp;
    user_t      user;
  } b_chan_t;

  typedef struct packed {
    id_slv_t    id;
    logic [1:0] resp;
    user_t      user;
  } b_chan_slv_t;

  typedef struct packed {
    id_t        id;
    data_t      data;
    logic [1:0] resp;
    logic       last;
    user_t      user;
  } r_chan_t;

  typedef struct packed {
    id_slv_t    id;
    data_t      data;
    logic [1:0] resp;
    logic       last;
    user_t      user;
  } r_chan_slv_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } resp_t;

  typedef struct packed {
    aw_chan_slv_t aw;
    logic         aw_valid;
    w_chan_t      w;
    logic         w_valid;
    logic         b_ready;
    ar_chan_slv_t ar;
    logic         ar_valid;
    logic         r_ready;
  } req_slv_t;

  typedef struct packed {
    logic        aw_ready;
    logic        ar_ready;
    logic        w_ready;
    logic        b_valid;
    b_chan_slv_t b;
    logic        r_valid;
    r_chan_slv_t r;
  } resp_slv_t;

endpackage

// File: rtl/tapasco_axi_mux2.sv
// Two-to-one AXI4 mux: round-robin AW/AR arbitration with grant locking, W routed
// in AW grant order through a small index FIFO, B/R returned by the ID MSB.
module tapasco_axi_mux2 #(
  parameter int unsigned WFifoDepth = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  tapasco_axi::req_t      in0_req_i,
  output tapasco_axi::resp_t     in0_resp_o,
  input  tapasco_axi::req_t      in1_req_i,
  output tapasco_axi::resp_t     in1_resp_o,
  output tapasco_axi::req_slv_t  out_req_o,
  input  tapasco_axi::resp_slv_t out_resp_i
);
  import tapasco_axi::*;

  localparam int unsigned PtrW = (WFifoDepth > 1) ? $clog2(WFifoDepth) : 1;
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [0:0] {ARB_IDLE = 1'b0, ARB_LOCKED = 1'b1} arb_state_e;

  req_t            in_req_s  [2];
  resp_t           in_resp_s [2];

  arb_state_e      aw_state_r, ar_state_r;
  logic            aw_lock_idx_r, ar_lock_idx_r;
  logic            aw_prio_r, ar_prio_r;
  logic            aw_sel_valid_s, aw_sel_idx_s, aw_hs_s;
  logic            ar_sel_valid_s, ar_sel_idx_s, ar_hs_s;

  logic [WFifoDepth-1:0] fifo_mem_r;
  logic [PtrW-1:0] wr_ptr_r, rd_ptr_r;
  logic [CntW-1:0] count_r;
  logic            fifo_full_s, fifo_empty_s, w_head_s, w_valid_s, w_pop_s;
  logic            b_sel_s, r_sel_s;

  function automatic logic rr_pick(input logic v0, input logic v1, input logic prio);
    logic pick;
    if (v0 && v1) begin
      pick = prio;
    end else if (v1) begin
      pick = 1'b1;
    end else begin
      pick = 1'b0;
    end
    return pick;
  endfunction

  assign in_req_s[0] = in0_req_i;
  assign in_req_s[1] = in1_req_i;
  assign in0_resp_o  = in_resp_s[0];
  assign in1_resp_o  = in_resp_s[1];

  assign fifo_full_s  = (count_r == CntW'(WFifoDepth));
  assign fifo_empty_s = (count_r == CntW'(0));
  assign w_head_s     = fifo_mem_r[rd_ptr_r];
  assign w_valid_s    = rst_ni & ~fifo_empty_s & in_req_s[w_head_s].w_valid;
  assign w_pop_s      = w_valid_s & out_resp_i.w_ready & in_req_s[w_head_s].w.last;
  assign aw_hs_s      = aw_sel_valid_s & out_resp_i.aw_ready;
  assign ar_hs_s      = ar_sel_valid_s & out_resp_i.ar_ready;
  assign b_sel_s      = out_resp_i.b.id[IdWidth];
  assign r_sel_s      = out_resp_i.r.id[IdWidth];

  // AW selection: a full W FIFO stalls the channel; a locked grant overrides priority
  always_comb begin
    aw_sel_valid_s = 1'b0;
    aw_sel_idx_s   = 1'b0;
    if (!rst_ni || fifo_full_s) begin
      aw_sel_valid_s = 1'b0;
      aw_sel_idx_s   = 1'b0;
    end else if (aw_state_r == ARB_LOCKED) begin
      aw_sel_idx_s   = aw_lock_idx_r;
      aw_sel_valid_s = in_req_s[aw_lock_idx_r].aw_valid;
    end else begin
      aw_sel_idx_s   = rr_pick(in_req_s[0].aw_valid, in_req_s[1].aw_valid, aw_prio_r);
      aw_sel_valid_s = in_req_s[0].aw_valid | in_req_s[1].aw_valid;
    end
  end

  // AR selection: same policy as AW without the FIFO dependency
  always_comb begin
    ar_sel_valid_s = 1'b0;
    ar_sel_idx_s   = 1'b0;
    if (!rst_ni) begin
      ar_sel_valid_s = 1'b0;
      ar_sel_idx_s   = 1'b0;
    end else if (ar_state_r == ARB_LOCKED) begin
      ar_sel_idx_s   = ar_lock_idx_r;
      ar_sel_valid_s = in_req_s[ar_lock_idx_r].ar_valid;
    end else begin
      ar_sel_idx_s   = rr_pick(in_req_s[0].ar_valid, in_req_s[1].ar_valid, ar_prio_r);
      ar_sel_valid_s = in_req_s[0].ar_valid | in_req_s[1].ar_valid;
    end
  end

  // AW arbiter FSM: lock an unaccepted grant, hand priority to the loser on handshake
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      aw_state_r    <= ARB_IDLE;
      aw_lock_idx_r <= 1'b0;
      aw_prio_r     <= 1'b0;
    end else begin
      case (aw_state_r)
        ARB_IDLE: begin
          if (aw_hs_s) begin
            aw_prio_r <= ~aw_sel_idx_s;
          end else if (aw_sel_valid_s) begin
            aw_state_r    <= ARB_LOCKED;
            aw_lock_idx_r <= aw_sel_idx_s;
          end
        end
        ARB_LOCKED: begin
          if (aw_hs_s) begin
            aw_state_r <= ARB_IDLE;
            aw_prio_r  <= ~aw_sel_idx_s;
          end
        end
        default: aw_state_r <= ARB_IDLE;
      endcase
    end
  end

  // AR arbiter FSM
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ar_state_r    <= ARB_IDLE;
      ar_lock_idx_r <= 1'b0;
      ar_prio_r     <= 1'b0;
    end else begin
      case (ar_state_r)
        ARB_IDLE: begin
          if (ar_hs_s) begin
            ar_prio_r <= ~ar_sel_idx_s;
          end else if (ar_sel_valid_s) begin
            ar_state_r    <= ARB_LOCKED;
            ar_lock_idx_r <= ar_sel_idx_s;
          end
        end
        ARB_LOCKED: begin
          if (ar_hs_s) begin
            ar_state_r <= ARB_IDLE;
            ar_prio_r  <= ~ar_sel_idx_s;
          end
        end
        default: ar_state_r <= ARB_IDLE;
      endcase
    end
  end

  // W routing FIFO: one master index per granted AW, popped on the last W beat
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fifo_mem_r <= '0;
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
    end else begin
      if (aw_hs_s) begin
        fifo_mem_r[wr_ptr_r] <= aw_sel_idx_s;
        wr_ptr_r             <= wr_ptr_r + PtrW'(1);
      end
      if (w_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PtrW'(1);
      end
      case ({aw_hs_s, w_pop_s})
        2'b10:   count_r <= count_r + CntW'(1);
        2'b01:   count_r <= count_r - CntW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Slave-side request: the channel structs keep id on top, so prepending the index widens it
  always_comb begin
    out_req_o          = '0;
    out_req_o.aw       = {aw_sel_idx_s, in_req_s[aw_sel_idx_s].aw};
    out_req_o.aw_valid = aw_sel_valid_s;
    out_req_o.w        = in_req_s[w_head_s].w;
    out_req_o.w_valid  = w_valid_s;
    out_req_o.b_ready  = rst_ni & in_req_s[b_sel_s].b_ready;
    out_req_o.ar       = {ar_sel_idx_s, in_req_s[ar_sel_idx_s].ar};
    out_req_o.ar_valid = ar_sel_valid_s;
    out_req_o.r_ready  = rst_ni & in_req_s[r_sel_s].r_ready;
  end

  // Master-side responses: readies only to the selected master, B/R valid only to the addressed one
  always_comb begin
    in_resp_s[0] = '0;
    in_resp_s[1] = '0;
    in_resp_s[aw_sel_idx_s].aw_ready = aw_sel_valid_s & out_resp_i.aw_ready;
    in_resp_s[ar_sel_idx_s].ar_ready = ar_sel_valid_s & out_resp_i.ar_ready;
    if (rst_ni && !fifo_empty_s) begin
      in_resp_s[w_head_s].w_ready = out_resp_i.w_ready;
    end else begin
      in_resp_s[w_head_s].w_ready = 1'b0;
    end
    for (int i = 0; i < 2; i++) begin
      in_resp_s[i].b.id   = out_resp_i.b.id[IdWidth-1:0];
      in_resp_s[i].b.resp = out_resp_i.b.resp;
      in_resp_s[i].b.user = out_resp_i.b.user;
      in_resp_s[i].b_valid = rst_ni & out_resp_i.b_valid & (b_sel_s == 1'(i));
      in_resp_s[i].r.id   = out_resp_i.r.id[IdWidth-1:0];
      in_resp_s[i].r.data = out_resp_i.r.data;
      in_resp_s[i].r.resp = out_resp_i.r.resp;
      in_resp_s[i].r.last = out_resp_i.r.last;
      in_resp_s[i].r.user = out_resp_i.r.user;
      in_resp_s[i].r_valid = rst_ni & out_resp_i.r_valid & (r_sel_s == 1'(i));
    end
  end

endmodule
